perm_unrolled_core: RTL and testbench

PERM_UNROLLED_CORE -- requirements
Module: perm_unrolled_core

---
 rtl/perm_unrolled_core.sv | 105 ++++++++++
 tb/tb_perm_unrolled_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/perm_unrolled_core.sv
// perm_unrolled_core: ASCON permutation applying UNROLL rounds per clock, IDLE/RUN/DONE control.
// Optional PERM_ABORT_EN adds abort_i to cancel a permutation in flight.
package perm_pkg;
    typedef logic [319:0] type_state;
endpackage

module perm_unrolled_core
    import perm_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] nb_rounds_i,
    input  type_state  state_i,
`ifdef PERM_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       busy_o,
    output logic       done_o,
    output type_state  state_o
);
    localparam int IW = $clog2(MAX_ROUNDS + UNROLL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [IW-1:0]   rnd_q, rnd_d, base, nxt;
    logic [3:0]      r_clamp;
    type_state       state_q, state_d, cur;
    logic            accept, last, abort;

`ifdef PERM_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // round constant for index i: high nibble counts down, low nibble counts up
    function automatic logic [7:0] rc_f(input int i);
        return {4'(15 - i), 4'(i)};
    endfunction

    function automatic type_state round_f(input type_state s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, c};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        return {x0 ^ ror(x0, 19) ^ ror(x0, 28),
                x1 ^ ror(x1, 61) ^ ror(x1, 39),
                x2 ^ ror(x2, 1)  ^ ror(x2, 6),
                x3 ^ ror(x3, 10) ^ ror(x3, 17),
                x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
    endfunction

    always_comb begin
        accept  = start_i && fsm_q != RUN;
        r_clamp = (nb_rounds_i == 4'd0 || int'(nb_rounds_i) > MAX_ROUNDS) ? 4'(MAX_ROUNDS) : nb_rounds_i;
        base    = accept ? IW'(MAX_ROUNDS - int'(r_clamp)) : rnd_q;
        cur     = accept ? state_i : state_q;
        // stages past the last round index pass through, covering R mod UNROLL tails
        for (int u = 0; u < UNROLL; u++)
            cur = (int'(base) + u < MAX_ROUNDS) ? round_f(cur, rc_f(int'(base) + u)) : cur;
        nxt     = base + IW'(UNROLL);
        last    = int'(nxt) >= MAX_ROUNDS;
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        if (accept || (fsm_q == RUN && !abort)) begin
            state_d = cur;
            rnd_d   = last ? IW'(MAX_ROUNDS) : nxt;
            fsm_d   = last ? DONE : RUN;
        end else if (fsm_q != IDLE) begin
            fsm_d   = IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign busy_o  = fsm_q == RUN;
    assign done_o  = fsm_q == DONE;
    assign state_o = state_q;
endmodule

// File: tb/tb_perm_unrolled_core.sv
// tb_perm_unrolled_core: directed checks of perm_unrolled_core at UNROLL 1, 2 and 4 against a table-driven ASCON model.
module tb_perm_unrolled_core;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   nb;
    logic [319:0] sin;
    logic         busy1, done1, busy2, done2, busy4, done4;
    logic [319:0] st1, st2, st4;
`ifdef PERM_ABORT_EN
    logic         abort;
`endif
    int           total = 0, passed = 0, seen;

    localparam logic [319:0] PA = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                                   64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafebabe};
    localparam logic [319:0] PB = {64'h8000000000000000, 64'h0, 64'h1, 64'hffffffffffffffff, 64'h5555aaaa5555aaaa};
    localparam logic [319:0] PC = {64'h00400c0000000000, 64'h0011223344556677, 64'h8899aabbccddeeff,
                                   64'h0001020304050607, 64'h08090a0b0c0d0e0f};
    localparam logic [319:0] PD = {64'hcafef00dcafef00d, 64'h1357913579135791, 64'h2468024680246802,
                                   64'h0f0f0f0ff0f0f0f0, 64'h3c3c3c3cc3c3c3c3};

    logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                  5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                  5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                  5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    perm_unrolled_core #(.UNROLL(1)) u1 (.clock_i(clk), .reset_i(rst), .start_i(start), .nb_rounds_i(nb), .state_i(sin),
`ifdef PERM_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(busy1), .done_o(done1), .state_o(st1));
    perm_unrolled_core #(.UNROLL(2)) u2 (.clock_i(clk), .reset_i(rst), .start_i(start), .nb_rounds_i(nb), .state_i(sin),
`ifdef PERM_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(busy2), .done_o(done2), .state_o(st2));
    perm_unrolled_core #(.UNROLL(4)) u4 (.clock_i(clk), .reset_i(rst), .start_i(start), .nb_rounds_i(nb), .state_i(sin),
`ifdef PERM_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(busy4), .done_o(done4), .state_o(st4));

    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // first nrun rounds of an r-round permutation, S-box applied column-wise by lookup
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r, input int nrun);
        logic [63:0] x [5];
        logic [4:0]  v, o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int k = 0; k < nrun; k++) begin
            x[2][7:0] = x[2][7:0] ^ rc_tab[12 - r + k];
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox_tab[v];
                {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]} = o;
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_s(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; nb = 4'd0; sin = '0;
`ifdef PERM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        chk_b("rst busy1", busy1, 1'b0); chk_b("rst done1", done1, 1'b0); chk_s("rst st1", st1, '0);
        chk_b("rst busy2", busy2, 1'b0); chk_b("rst done2", done2, 1'b0); chk_s("rst st2", st2, '0);
        chk_b("rst busy4", busy4, 1'b0); chk_b("rst done4", done4, 1'b0); chk_s("rst st4", st4, '0);
        rst = 1'b0;

        // p12(0) on all three unroll factors, first start right after reset
        sin = '0; nb = 4'd12; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            chk_b($sformatf("t1 busy1 c%0d", c), busy1, c <= 11);
            chk_b($sformatf("t1 done1 c%0d", c), done1, c == 12);
            chk_b($sformatf("t1 done4 c%0d", c), done4, c == 3);
            chk_b($sformatf("t1 done2 c%0d", c), done2, c == 6);
        end
        chk_s("t1 st1", st1, ref_perm('0, 12, 12));
        chk_s("t1 st2 hold", st2, ref_perm('0, 12, 12));
        chk_s("t1 st4 hold", st4, ref_perm('0, 12, 12));
        tick();
        chk_b("t1 idle busy1", busy1, 1'b0);
        chk_b("t1 idle done1", done1, 1'b0);

        // six rounds: UNROLL=4 runs 4 then 2
        sin = PA; nb = 4'd6; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            chk_b($sformatf("t2 busy4 c%0d", c), busy4, c == 1);
            chk_b($sformatf("t2 done4 c%0d", c), done4, c == 2);
            chk_b($sformatf("t2 done2 c%0d", c), done2, c == 3);
            chk_b($sformatf("t2 done1 c%0d", c), done1, c == 6);
            if (c == 2) chk_s("t2 st4", st4, ref_perm(PA, 6, 6));
            if (c == 3) chk_s("t2 st2", st2, ref_perm(PA, 6, 6));
        end
        chk_s("t2 st1", st1, ref_perm(PA, 6, 6));
        tick();

        // out-of-range round counts clamp to 12
        for (int k = 0; k < 2; k++) begin
            sin = k == 0 ? PB : PC; nb = k == 0 ? 4'd0 : 4'd15; start = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                tick();
                start = 1'b0;
                chk_b($sformatf("t3.%0d done2 c%0d", k, c), done2, c == 6);
                if (c == 6) chk_s($sformatf("t3.%0d st2", k), st2, ref_perm(k == 0 ? PB : PC, 12, 12));
            end
            chk_s($sformatf("t3.%0d st1", k), st1, ref_perm(k == 0 ? PB : PC, 12, 12));
            tick();
        end

        // start while running is ignored; start in the done cycle runs back-to-back
        sin = PC; nb = 4'd12; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = 1'b0;
            chk_b($sformatf("t4 busy1 c%0d", c), busy1, c != 12 && c != 24);
            chk_b($sformatf("t4 done1 c%0d", c), done1, c == 12 || c == 24);
            if (c == 12) chk_s("t4 st1 first", st1, ref_perm(PC, 12, 12));
            if (c == 3 || c == 12) begin
                start = 1'b1; sin = PD; nb = c == 3 ? 4'd1 : 4'd12;
            end
        end
        chk_s("t4 st1 second", st1, ref_perm(PD, 12, 12));
        tick();

        // reset mid-run discards everything
        sin = PC; nb = 4'd12; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        chk_b("t5 busy1 before rst", busy1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("t5 busy1", busy1, 1'b0);
        chk_b("t5 done1", done1, 1'b0);
        chk_s("t5 st1", st1, '0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done1) seen++;
        end
        chk_b("t5 no done1", seen != 0, 1'b0);

        // abort at cycle 4 (or a normal finish when abort is not built in)
        sin = PA; nb = 4'd12; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
`ifdef PERM_ABORT_EN
            if (c == 4) abort = 1'b1;
`endif
        end
`ifdef PERM_ABORT_EN
        tick();
        abort = 1'b0;
        chk_b("t6 busy1", busy1, 1'b0);
        chk_b("t6 done1", done1, 1'b0);
        chk_s("t6 st1 partial", st1, ref_perm(PA, 12, 4));
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done1) seen++;
        end
        chk_b("t6 no done1", seen != 0, 1'b0);
        chk_s("t6 st1 held", st1, ref_perm(PA, 12, 4));
`else
        for (int c = 5; c <= 12; c++) begin
            tick();
            chk_b($sformatf("t6 done1 c%0d", c), done1, c == 12);
        end
        chk_s("t6 st1", st1, ref_perm(PA, 12, 12));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
